grasspopper_decoder: RTL and testbench

//  Iterative GOST R 34.12-2015 "Kuznyechik" block decryptor, the inverse of the grasspopper encoder.

---
 rtl/gp_pkg.sv | 68 ++++++
 rtl/gp_r_inv.sv | 21 ++
 rtl/grasspopper_decoder.sv | 99 +++++++++
 tb/tb_grasspopper_decoder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/gp_pkg.sv
// Shared constants and helpers for the Kuznyechik (GOST R 34.12-2015) encoder/decoder pair:
// S-box tables, linear-layer coefficients, GF(2^8) multiply, default key schedule and FSM states.
package gp_pkg;

    localparam logic [7:0] PI [256] = '{
        8'd252, 8'd238, 8'd221, 8'd17,  8'd207, 8'd110, 8'd49,  8'd22,  8'd251, 8'd196, 8'd250, 8'd218, 8'd35,  8'd197, 8'd4,   8'd77,
        8'd233, 8'd119, 8'd240, 8'd219, 8'd147, 8'd46,  8'd153, 8'd186, 8'd23,  8'd54,  8'd241, 8'd187, 8'd20,  8'd205, 8'd95,  8'd193,
        8'd249, 8'd24,  8'd101, 8'd90,  8'd226, 8'd92,  8'd239, 8'd33,  8'd129, 8'd28,  8'd60,  8'd66,  8'd139, 8'd1,   8'd142, 8'd79,
        8'd5,   8'd132, 8'd2,   8'd174, 8'd227, 8'd106, 8'd143, 8'd160, 8'd6,   8'd11,  8'd237, 8'd152, 8'd127, 8'd212, 8'd211, 8'd31,
        8'd235, 8'd52,  8'd44,  8'd81,  8'd234, 8'd200, 8'd72,  8'd171, 8'd242, 8'd42,  8'd104, 8'd162, 8'd253, 8'd58,  8'd206, 8'd204,
        8'd181, 8'd112, 8'd14,  8'd86,  8'd8,   8'd12,  8'd118, 8'd18,  8'd191, 8'd114, 8'd19,  8'd71,  8'd156, 8'd183, 8'd93,  8'd135,
        8'd21,  8'd161, 8'd150, 8'd41,  8'd16,  8'd123, 8'd154, 8'd199, 8'd243, 8'd145, 8'd120, 8'd111, 8'd157, 8'd158, 8'd178, 8'd177,
        8'd50,  8'd117, 8'd25,  8'd61,  8'd255, 8'd53,  8'd138, 8'd126, 8'd109, 8'd84,  8'd198, 8'd128, 8'd195, 8'd189, 8'd13,  8'd87,
        8'd223, 8'd245, 8'd36,  8'd169, 8'd62,  8'd168, 8'd67,  8'd201, 8'd215, 8'd121, 8'd214, 8'd246, 8'd124, 8'd34,  8'd185, 8'd3,
        8'd224, 8'd15,  8'd236, 8'd222, 8'd122, 8'd148, 8'd176, 8'd188, 8'd220, 8'd232, 8'd40,  8'd80,  8'd78,  8'd51,  8'd10,  8'd74,
        8'd167, 8'd151, 8'd96,  8'd115, 8'd30,  8'd0,   8'd98,  8'd68,  8'd26,  8'd184, 8'd56,  8'd130, 8'd100, 8'd159, 8'd38,  8'd65,
        8'd173, 8'd69,  8'd70,  8'd146, 8'd39,  8'd94,  8'd85,  8'd47,  8'd140, 8'd163, 8'd165, 8'd125, 8'd105, 8'd213, 8'd149, 8'd59,
        8'd7,   8'd88,  8'd179, 8'd64,  8'd134, 8'd172, 8'd29,  8'd247, 8'd48,  8'd55,  8'd107, 8'd228, 8'd136, 8'd217, 8'd231, 8'd137,
        8'd225, 8'd27,  8'd131, 8'd73,  8'd76,  8'd63,  8'd248, 8'd254, 8'd141, 8'd83,  8'd170, 8'd144, 8'd202, 8'd216, 8'd133, 8'd97,
        8'd32,  8'd113, 8'd103, 8'd164, 8'd45,  8'd43,  8'd9,   8'd91,  8'd203, 8'd155, 8'd37,  8'd208, 8'd190, 8'd229, 8'd108, 8'd82,
        8'd89,  8'd166, 8'd116, 8'd210, 8'd230, 8'd244, 8'd180, 8'd192, 8'd209, 8'd102, 8'd175, 8'd194, 8'd57,  8'd75,  8'd99,  8'd182
    };

    typedef logic [255:0][7:0] sbox_t;

    // The inverse table is derived from the forward one so the two can never disagree.
    function automatic sbox_t invert_pi();
        sbox_t r;
        r = '0;
        for (int i = 0; i < 256; i++) r[PI[i]] = 8'(i);
        return r;
    endfunction

    localparam sbox_t PI_INV = invert_pi();

    localparam logic [7:0] L_COEF [16] = '{
        8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
        8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
    };

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x;
        logic [7:0] p;
        x = a;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'hC3 : 8'h00);
        end
        return p;
    endfunction

    localparam logic [9:0][127:0] DEFAULT_RKEYS = {
        128'h72e9dd7416bcf45b755dbaa88e4a4043,
        128'hbb44e25378c73123a5f32f73cdb6e517,
        128'h5a7925017b9fdd3ed72a91a22286f984,
        128'h51e640757e8745de705727265a0098b1,
        128'hbd079435165c6432b532e82834da581b,
        128'h57646468c44a5e28d3e59246f429f1ac,
        128'h3d4553d8e9cfec6815ebadc40a9ffd04,
        128'hdb31485315694343228d6aef8cc78c44,
        128'hfedcba98765432100123456789abcdef,
        128'h8899aabbccddeeff0011223344556677
    };

    typedef enum logic [1:0] {IDLE, LINV, SXOR, DONE} state_t;

endpackage

// File: rtl/gp_r_inv.sv
// One inverse R step of the Kuznyechik linear layer: shift the block up a byte and
// append the l-function of the rotated byte sequence.
module gp_r_inv
    import gp_pkg::*;
(
    input  logic [127:0] a,
    output logic [127:0] y
);

    logic [7:0] l;

    // l sees (a14 .. a0, a15): a15 moves to the end and takes the last coefficient.
    always_comb begin
        l = gf_mul(L_COEF[15], a[127:120]);
        for (int i = 0; i < 15; i++)
            l = l ^ gf_mul(L_COEF[i], a[8*(14-i) +: 8]);
    end

    assign y = {a[119:0], l};

endmodule

// File: rtl/grasspopper_decoder.sv
// Iterative Kuznyechik block decryptor with request/busy/valid/ack handshake;
// LINV_UNROLL inverse-R steps are applied per clock.
module grasspopper_decoder
    import gp_pkg::*;
#(
    parameter logic [9:0][127:0] RKEYS       = DEFAULT_RKEYS,
    parameter int unsigned       LINV_UNROLL = 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [127:0] data_i,
    input  logic         request_i,
    input  logic         ack_i,
    output logic [127:0] data_o,
    output logic         valid_o,
    output logic         busy_o
);

    localparam logic [4:0] STEP_INC = 5'(LINV_UNROLL);

    state_t       state;
    logic [127:0] st;
    logic [3:0]   round;
    logic [4:0]   step;
    logic [4:0]   step_next;
    logic [127:0] sx;
    logic [127:0] chain [LINV_UNROLL+1];

    assign chain[0]  = st;
    assign step_next = step + STEP_INC;

    for (genvar g = 0; g < LINV_UNROLL; g++) begin : g_rinv
        gp_r_inv u_r_inv (
            .a (chain[g]),
            .y (chain[g+1])
        );
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        sx = '0;
        for (int b = 0; b < 16; b++)
            sx[8*b +: 8] = PI_INV[st[8*b +: 8]];
        sx = sx ^ RKEYS[round];
    end

    // NOTE: state is updated with non-blocking assignments so every register samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            st      <= '0;
            round   <= '0;
            step    <= '0;
            data_o  <= '0;
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (request_i) begin
                        st     <= data_i ^ RKEYS[9];
                        round  <= 4'd8;
                        step   <= '0;
                        busy_o <= 1'b1;
                        state  <= LINV;
                    end
                end
                LINV: begin
                    st   <= chain[LINV_UNROLL];
                    step <= step_next;
                    if (step_next == 5'd16) state <= SXOR;
                end
                SXOR: begin
                    st <= sx;
                    if (round == 4'd0) begin
                        data_o  <= sx;
                        valid_o <= 1'b1;
                        state   <= DONE;
                    end else begin
                        round <= round - 4'd1;
                        step  <= '0;
                        state <= LINV;
                    end
                end
                DONE: begin
                    // ack has priority; a request seen here is simply dropped
                    if (ack_i) begin
                        valid_o <= 1'b0;
                        busy_o  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_grasspopper_decoder.sv
// Self-checking bench: a behavioural Kuznyechik encryptor (with its own key expansion)
// produces ciphertexts whose decryption by the DUT must give back the original block.
module tb_grasspopper_decoder;

    localparam logic [127:0] KAT_C = 128'h7f679d90bebc24305a468d42b9d4edcd;
    localparam logic [127:0] KAT_P = 128'h1122334455667700ffeeddccbbaa9988;

    logic         clk = 1'b0;
    logic         resetn;
    logic [127:0] data, data16;
    logic         req, req16, ack, ack16;
    logic [127:0] pt, pt16;
    logic         valid, valid16, busy, busy16;
    logic [127:0] rin;
    wire  [127:0] rchain [17];

    int checks   = 0;
    int failures = 0;

    logic [7:0]   lc [16] = '{8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
                              8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1};
    logic [127:0] rk [10];

    always #5 clk = ~clk;

    grasspopper_decoder #(.LINV_UNROLL(1)) dut (
        .clk(clk), .resetn(resetn), .data_i(data), .request_i(req), .ack_i(ack),
        .data_o(pt), .valid_o(valid), .busy_o(busy)
    );

    grasspopper_decoder #(.LINV_UNROLL(16)) dut16 (
        .clk(clk), .resetn(resetn), .data_i(data16), .request_i(req16), .ack_i(ack16),
        .data_o(pt16), .valid_o(valid16), .busy_o(busy16)
    );

    assign rchain[0] = rin;
    for (genvar g = 0; g < 16; g++) begin : g_rinv
        gp_r_inv u_r_inv (.a(rchain[g]), .y(rchain[g+1]));
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model: forward cipher ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p ^= 15'(a) << i;
        for (int i = 14; i >= 8; i--) if (p[i]) p ^= 15'h1C3 << (i - 8);
        return p[7:0];
    endfunction

    function automatic logic [127:0] sub(input logic [127:0] x);
        logic [127:0] r;
        for (int b = 0; b < 16; b++) r[8*b +: 8] = gp_pkg::PI[x[8*b +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] lin(input logic [127:0] x);
        logic [7:0] l;
        for (int r = 0; r < 16; r++) begin
            l = '0;
            for (int j = 0; j < 16; j++) l ^= gmul(lc[j], x[8*(15-j) +: 8]);
            x = {l, x[127:8]};
        end
        return x;
    endfunction

    function automatic logic [127:0] enc(input logic [127:0] p);
        logic [127:0] a;
        a = p;
        for (int r = 0; r < 9; r++) a = lin(sub(a ^ rk[r]));
        return a ^ rk[9];
    endfunction

    task automatic expand_keys();
        logic [255:0] key;
        logic [127:0] k1, k0, t;
        key = 256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
        k1 = key[255:128];
        k0 = key[127:0];
        rk[0] = k1;
        rk[1] = k0;
        for (int i = 1; i <= 32; i++) begin
            t  = lin(sub(k1 ^ lin(128'(i)))) ^ k0;
            k0 = k1;
            k1 = t;
            if (i % 8 == 0) begin
                rk[i/4]   = k1;
                rk[i/4+1] = k0;
            end
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit u16, input logic r, input logic a, input logic [127:0] d);
        if (u16) begin
            req16 = r; ack16 = a; data16 = d;
        end else begin
            req = r; ack = a; data = d;
        end
    endtask

    function automatic logic get_valid(input bit u16);
        return u16 ? valid16 : valid;
    endfunction

    function automatic logic get_busy(input bit u16);
        return u16 ? busy16 : busy;
    endfunction

    function automatic logic [127:0] get_data(input bit u16);
        return u16 ? pt16 : pt;
    endfunction

    // One full transaction: accept, wait for valid (bounded), hold in DONE, acknowledge.
    task automatic decode(input bit u16, input logic [127:0] c, input logic [127:0] exp,
                          input int lat, input bit spam, input bit ack_req, input string tag);
        int n;
        int drops;
        drive(u16, 1'b1, 1'b0, c);
        @(posedge clk); #1;
        n = 1;
        drops = 0;
        drive(u16, 1'b0, 1'b0, rand128());
        while (!get_valid(u16) && n < 400) begin
            if (!get_busy(u16)) drops++;
            if (spam) drive(u16, 1'b1, 1'($urandom), rand128());
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 128'(n), 128'(lat));
        check({tag, "_data"}, get_data(u16), exp);
        check({tag, "_busy_gaps"}, 128'(drops), 128'(0));

        drive(u16, spam, 1'b0, rand128());
        @(posedge clk); #1;
        check({tag, "_done_valid"}, 128'(get_valid(u16)), 128'(1));
        check({tag, "_done_hold"}, get_data(u16), exp);

        drive(u16, ack_req, 1'b1, rand128());
        @(posedge clk); #1;
        drive(u16, 1'b0, 1'b0, rand128());
        check({tag, "_ack_valid"}, 128'(get_valid(u16)), 128'(0));
        check({tag, "_ack_busy"}, 128'(get_busy(u16)), 128'(0));

        @(posedge clk); #1;
        check({tag, "_idle_busy"}, 128'(get_busy(u16)), 128'(0));
        check({tag, "_idle_valid"}, 128'(get_valid(u16)), 128'(0));
    endtask

    initial begin
        logic [127:0] p;

        resetn = 1'b0;
        req = 1'b0; ack = 1'b0; data = '0;
        req16 = 1'b0; ack16 = 1'b0; data16 = '0;
        rin = '0;
        expand_keys();

        #12;
        check("reset_data", pt, 128'h0);
        check("reset_valid", 128'(valid), 128'(0));
        check("reset_busy", 128'(busy), 128'(0));
        check("reset16_data", pt16, 128'h0);
        check("reset16_valid", 128'(valid16), 128'(0));
        check("reset16_busy", 128'(busy16), 128'(0));
        @(negedge clk);
        resetn = 1'b1;

        rin = 128'hd456584dd0e3e84cc3166e4b7fa2890d;
        #1;
        check("rinv_chain16", rchain[16], 128'h64a59400000000000000000000000000);

        // ack while idle must not disturb anything
        @(posedge clk); #1;
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        check("ack_idle_valid", 128'(valid), 128'(0));
        check("ack_idle_busy", 128'(busy), 128'(0));

        decode(1'b0, KAT_C, KAT_P, 154, 1'b0, 1'b0, "kat");
        decode(1'b0, KAT_C, KAT_P, 154, 1'b1, 1'b0, "spam");

        for (int i = 0; i < 11; i++) begin
            p = rand128();
            decode(1'b0, enc(p), p, 154, 1'b0, 1'b0, "loop");
        end

        // abort at step 7 of round 4 (edge 76 counting the accepting edge as 1)
        p = rand128();
        drive(1'b0, 1'b1, 1'b0, enc(p));
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, '0);
        repeat (75) @(posedge clk);
        #1;
        check("abort_busy_before", 128'(busy), 128'(1));
        resetn = 1'b0;
        #1;
        check("abort_valid", 128'(valid), 128'(0));
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_data", pt, 128'h0);
        @(posedge clk); #1;
        resetn = 1'b1;
        p = rand128();
        decode(1'b0, enc(p), p, 154, 1'b0, 1'b0, "after_abort");

        decode(1'b1, KAT_C, KAT_P, 19, 1'b0, 1'b1, "u16_kat");
        for (int i = 0; i < 3; i++) begin
            p = rand128();
            decode(1'b1, enc(p), p, 19, 1'b1, 1'b1, "u16_loop");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
